// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM request arbiter.
package psram_pkg;

    localparam int PSRAM_AW = 23;
    localparam int PSRAM_DW = 16;

    localparam logic [1:0] RW_NONE  = 2'd0;
    localparam logic [1:0] RW_WRITE = 2'd1;
    localparam logic [1:0] RW_READ  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_GUARD,
        ST_BUSY,
        ST_DONE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/psram_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the winner is remembered only when i_update is high.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_grant
);

    logic r_last_grant;

    always_comb begin
        if (i_req == 2'b11) begin
            o_grant = ~r_last_grant;
        end else begin
            o_grant = i_req[1];
        end
    end

    // Reset to 1 so port 0 wins the first contended grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_update) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port round-robin sequencer in front of the psram controller, with
// CE-high gap enforcement and a BUSY watchdog.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for qpi_on and a valid request
// ST_ARB   | pulse req_ready to the winner, latch its command fields
// ST_START | quad_start pulse, command driven to psram
// ST_GUARD | endcommand ignored (still high from previous transaction)
// ST_BUSY  | wait for endcommand, watchdog running
// ST_DONE  | response pulse
// ST_GAP   | enforced idle before the next grant
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int TIMEOUT      = 64,
    parameter int GUARD_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                i_mem_clk,
    input  logic                i_rst_n,
    input  logic [1:0]          i_req_valid,
    input  logic [1:0]          i_req_we,
    input  logic [PSRAM_AW-1:0] i_req_addr0,
    input  logic [PSRAM_AW-1:0] i_req_addr1,
    input  logic [PSRAM_DW-1:0] i_req_wdata0,
    input  logic [PSRAM_DW-1:0] i_req_wdata1,
    output logic [1:0]          o_req_ready,
    output logic                o_rsp_valid,
    output logic                o_rsp_id,
    output logic [PSRAM_DW-1:0] o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_busy,
    output logic                o_timeout_err,
    input  logic                i_qpi_on,
    input  logic                i_endcommand,
    input  logic [PSRAM_DW-1:0] i_data_out,
    output logic                o_quad_start,
    output logic [1:0]          o_read_write,
    output logic [PSRAM_AW-1:0] o_address,
    output logic [PSRAM_DW-1:0] o_data_in
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic                r_owner;
    logic                w_grant;
    logic                w_arb_update;
    logic                w_timeout;
    logic                w_done;
    logic                w_sel_we;
    logic [PSRAM_AW-1:0] w_sel_addr;
    logic [PSRAM_DW-1:0] w_sel_wdata;

    logic [1:0]          r_req_ready;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [PSRAM_DW-1:0] r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_busy;
    logic                r_timeout_err;
    logic                r_quad_start;
    logic [1:0]          r_read_write;
    logic [PSRAM_AW-1:0] r_address;
    logic [PSRAM_DW-1:0] r_data_in;

    rr_arb2 u_rr_arb2 (
        .i_clk    (i_mem_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req_valid),
        .i_update (w_arb_update),
        .o_grant  (w_grant)
    );

    assign w_sel_we    = r_owner ? i_req_we[1]  : i_req_we[0];
    assign w_sel_addr  = r_owner ? i_req_addr1  : i_req_addr0;
    assign w_sel_wdata = r_owner ? i_req_wdata1 : i_req_wdata0;

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE:  if (i_qpi_on && (i_req_valid != 2'b00)) w_state_nxt = ST_ARB;
            ST_ARB:   w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_GUARD;
            ST_GUARD: if (r_cnt == GUARD_LAST) w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                // endcommand takes priority over a coincident watchdog expiry
                if (i_endcommand) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_timeout   = 1'b1;
                end
            end
            ST_DONE:  w_state_nxt = ST_GAP;
            ST_GAP:   if (r_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_arb_update = (r_state == ST_IDLE) && (w_state_nxt == ST_ARB);
    assign w_done       = (r_state == ST_BUSY) && (w_state_nxt == ST_DONE);

    always_ff @(posedge i_mem_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_owner       <= 1'b0;
            r_req_ready   <= 2'b00;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_quad_start  <= 1'b0;
            r_read_write  <= RW_NONE;
            r_address     <= '0;
            r_data_in     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_req_ready <= 2'b00;
            if (w_arb_update) begin
                r_req_ready <= w_grant ? 2'b10 : 2'b01;
                r_owner     <= w_grant;
            end

            // The command registers double as the psram-facing outputs.
            if (r_state == ST_ARB) begin
                r_read_write <= w_sel_we ? RW_WRITE : RW_READ;
                r_address    <= w_sel_addr;
                r_data_in    <= w_sel_wdata;
            end else if (w_state_nxt == ST_DONE) begin
                r_read_write <= RW_NONE;
            end

            r_quad_start <= (w_state_nxt == ST_START);
            r_busy       <= (w_state_nxt != ST_IDLE);

            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            if (w_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_owner;
                r_rsp_err   <= w_timeout;
                if (!w_timeout && (r_read_write == RW_READ)) begin
                    r_rsp_rdata <= i_data_out;
                end
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_id      = r_rsp_id;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;
    assign o_quad_start  = r_quad_start;
    assign o_read_write  = r_read_write;
    assign o_address     = r_address;
    assign o_data_in     = r_data_in;

endmodule
